gf180mcu_fd_sc_mcu7t5v0__norn_pipe: RTL

GF180MCU_FD_SC_MCU7T5V0__NORN_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__norn_pipe

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__norn_pipe_pkg.sv | 33 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__norn_pipe_stage.sv | 81 ++++++++
 rtl/gf180mcu_fd_sc_mcu7t5v0__norn_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__norn_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined N-input NOR/OR reducer.
// Depth and per-stage term counts are derived from WIDTH and FANIN here so top and stages agree.
package gf180mcu_fd_sc_mcu7t5v0__norn_pipe_pkg;

  localparam logic MODE_NOR = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  localparam int HIT_CNT_W = 16;

  // Number of partial terms per channel entering the given stage.
  function automatic int norn_terms(input int width, input int fanin, input int stage);
    int n;
    n = width;
    for (int i = 0; i < stage; i++) begin
      n = (n + fanin - 1) / fanin;
    end
    return n;
  endfunction

  // Stage count: ceil(log_fanin(width)), never less than one register stage.
  function automatic int norn_lat(input int width, input int fanin);
    int n;
    int l;
    n = width;
    l = 0;
    while (n > 1) begin
      n = (n + fanin - 1) / fanin;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__norn_pipe_stage.sv
// One registered reduction stage: ORs groups of FANIN terms per channel, last stage applies MODE.
// Holds one beat; loads when empty or when its beat leaves in the same cycle.
module gf180mcu_fd_sc_mcu7t5v0__norn_pipe_stage
  import gf180mcu_fd_sc_mcu7t5v0__norn_pipe_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int IN_TERMS  = 8,
  parameter int FANIN     = 4,
  parameter int OUT_TERMS = (IN_TERMS + FANIN - 1) / FANIN,
  parameter bit LAST      = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_vld_i,
  output logic                          in_rdy_o,
  input  logic [CHANNELS*IN_TERMS-1:0]  dat_i,
  input  logic                          mode_i,
  output logic                          out_vld_o,
  input  logic                          out_rdy_i,
  output logic [CHANNELS*OUT_TERMS-1:0] dat_o,
  output logic                          mode_o
);

  localparam int PAD_W = OUT_TERMS * FANIN;

  logic                          vld_q, vld_d;
  logic                          mode_q, mode_d;
  logic [CHANNELS*OUT_TERMS-1:0] dat_q, dat_d;
  logic [CHANNELS*OUT_TERMS-1:0] red;
  logic [PAD_W-1:0]              pad;
  logic                          load;

  assign load     = ~vld_q | out_rdy_i;
  assign in_rdy_o = load;

  // Zero-pad each channel so a short final group ORs cleanly.
  always_comb begin
    red = '0;
    pad = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pad                 = '0;
      pad[IN_TERMS-1:0]   = dat_i[c*IN_TERMS +: IN_TERMS];
      for (int j = 0; j < OUT_TERMS; j++) begin
        red[c*OUT_TERMS + j] = |pad[j*FANIN +: FANIN];
        if (LAST && (mode_i == MODE_NOR)) begin
          red[c*OUT_TERMS + j] = ~red[c*OUT_TERMS + j];
        end
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    mode_d = mode_q;
    if (load) begin
      vld_d = in_vld_i;
      if (in_vld_i) begin
        dat_d  = red;
        mode_d = mode_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      mode_q <= MODE_NOR;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      mode_q <= mode_d;
    end
  end

  assign out_vld_o = vld_q;
  assign dat_o     = dat_q;
  assign mode_o    = mode_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__norn_pipe.sv
// Pipelined multi-channel NOR/OR reducer, LAT stages of radix FANIN with bubble-collapsing valid/ready.
// Optional hit counter enabled by GF180MCU_FD_SC_MCU7T5V0__NORN_PIPE_HITCNT_EN.
module gf180mcu_fd_sc_mcu7t5v0__norn_pipe
  import gf180mcu_fd_sc_mcu7t5v0__norn_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int FANIN    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic                      MODE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [CHANNELS-1:0]       ZN
`ifdef GF180MCU_FD_SC_MCU7T5V0__NORN_PIPE_HITCNT_EN
  ,
  input  logic                      CNT_CLR,
  output logic [HIT_CNT_W-1:0]      HIT_CNT
`endif
);

  localparam int LAT = norn_lat(WIDTH, FANIN);

  for (genvar s = 0; s < LAT; s++) begin : g_stg
    localparam int TI = norn_terms(WIDTH, FANIN, s);
    localparam int TO = norn_terms(WIDTH, FANIN, s + 1);

    logic [CHANNELS*TI-1:0] din;
    logic [CHANNELS*TO-1:0] dout;
    logic                   vin, min, rdy, vout, mout, rout;

    if (s == 0) begin : g_src
      assign din = A;
      assign vin = IN_VALID;
      assign min = MODE;
    end else begin : g_src
      assign din = g_stg[s-1].dout;
      assign vin = g_stg[s-1].vout;
      assign min = g_stg[s-1].mout;
    end

    if (s == LAT - 1) begin : g_snk
      assign rout = OUT_READY;
    end else begin : g_snk
      assign rout = g_stg[s+1].rdy;
    end

    gf180mcu_fd_sc_mcu7t5v0__norn_pipe_stage #(
      .CHANNELS  (CHANNELS),
      .IN_TERMS  (TI),
      .FANIN     (FANIN),
      .OUT_TERMS (TO),
      .LAST      (s == LAT - 1)
    ) u_stage (
      .clk_i     (CLK),
      .rst_i     (RST),
      .in_vld_i  (vin),
      .in_rdy_o  (rdy),
      .dat_i     (din),
      .mode_i    (min),
      .out_vld_o (vout),
      .out_rdy_i (rout),
      .dat_o     (dout),
      .mode_o    (mout)
    );
  end

  // The carried mode has already been applied inside the last stage.
  logic unused_last_mode;
  assign unused_last_mode = g_stg[LAT-1].mout;

  assign IN_READY  = g_stg[0].rdy & ~RST;
  assign OUT_VALID = g_stg[LAT-1].vout;
  assign ZN        = g_stg[LAT-1].dout;

`ifdef GF180MCU_FD_SC_MCU7T5V0__NORN_PIPE_HITCNT_EN
  logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (CNT_CLR) begin
      hit_cnt_d = '0;
    end else if (OUT_VALID && OUT_READY && (&ZN) && (hit_cnt_q != {HIT_CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign HIT_CNT = hit_cnt_q;
`endif

endmodule
